// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory port between the IF stage
//   (fetch) and the MEM stage (load/store). Only one transaction is
//   outstanding at a time. Data accesses win contention, but a streak
//   counter hands the port to a waiting fetch after FAIR_LIMIT consecutive
//   data grants. A fetch can be killed (branch/flush); the memory side
//   still completes, but its data and valid pulse are discarded.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_kill        fetch request, address, fetch discard
//   if_valid/if_rdata             fetch response pulse and registered data
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request fields
//   d_valid/d_rdata               data response pulse and registered load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered request to memory
//   mem_ready/mem_rvalid/mem_rdata  memory accept, response and read data
//   stall_if/stall_mem            pipeline stalls (request pending, not done)
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FAIR_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // Fetch port
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   input  logic                  if_kill,
   output logic                  if_valid,
   output logic [DATA_W-1:0]     if_rdata,
   // Data port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   output logic                  d_valid,
   output logic [DATA_W-1:0]     d_rdata,
   // Memory port
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   // Pipeline control
   output logic                  stall_if,
   output logic                  stall_mem
);

   localparam int unsigned StrbW   = DATA_W / 8;
   localparam logic [3:0]  FairLim = 4'(FAIR_LIMIT);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;  // 1 = fetch owns the port
   logic                kill_q, kill_d;
   logic [3:0]          streak_q, streak_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [StrbW-1:0]    mem_wstrb_q, mem_wstrb_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         kill_q      <= 1'b0;
         streak_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         kill_q      <= kill_d;
         streak_q    <= streak_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      kill_d      = kill_q;
      streak_d    = streak_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      // A kill only matters while a fetch owns the port; in IDLE it is ignored.
      if (if_kill && owner_q && (state_q != StIdle)) begin
         kill_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            // Data wins unless the waiting fetch has hit the fairness limit.
            if (d_req && !(if_req && (streak_q == FairLim))) begin
               owner_d     = 1'b0;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_wstrb_d = d_wstrb;
               if (!if_req) begin
                  streak_d = '0;
               end else if (streak_q != FairLim) begin
                  streak_d = streak_q + 4'd1;
               end
               state_d = StIssue;
            end else if (if_req) begin
               owner_d     = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_wstrb_d = '0;
               streak_d    = '0;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (mem_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_rvalid) begin
               state_d = StResp;
               if (owner_q) begin
                  // A kill arriving with the response still discards it.
                  if (!kill_q && !if_kill) begin
                     if_rdata_d = mem_rdata;
                  end
               end else if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
            kill_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mem_req   = (state_q == StIssue);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

   // A kill in the RESP cycle itself still suppresses the pulse.
   assign if_valid  = (state_q == StResp) && owner_q && !kill_q && !if_kill;
   assign d_valid   = (state_q == StResp) && !owner_q;

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, if_valid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_req, mem_we, mem_ready, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        stall_if, stall_mem;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   typedef struct {
      logic        is_fetch;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   rsp_t rsp_q[$];
   req_t req_q[$];
   int   nvec = 0;
   int   nbad = 0;
   int   cyc  = 0;
   int   ready_hold = 0;
   bit   hold_rsp   = 0;
   int   last_wait_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory model: accept after ready_hold cycles, respond the cycle after.
   initial begin : mem_model
      bit          pend;
      bit          busy;
      int          hold_left;
      logic [31:0] pdata;
      pend = 0; busy = 0; hold_left = 0; pdata = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ready  = 1'b0;
         mem_rvalid = 1'b0;
         if (pend) begin
            if (!hold_rsp) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pdata;
               pend       = 0;
            end
         end else if (mem_req) begin
            if (!busy) begin
               busy      = 1;
               hold_left = ready_hold;
            end
            if (hold_left > 0) begin
               hold_left--;
            end else begin
               mem_ready = 1'b1;
               busy      = 0;
               pend      = 1;
               pdata     = mem_data(mem_addr);
            end
         end
      end
   end

   // Monitor: pops scoreboard entries whenever the DUT presents a response or
   // a request is accepted by memory.
   initial begin : monitor
      rsp_t        r;
      req_t        q;
      bit          prev_wait;
      logic [31:0] p_addr, p_wdata;
      logic        p_we;
      logic [3:0]  p_wstrb;
      int          run;
      prev_wait = 0; run = 0;
      p_addr = '0; p_wdata = '0; p_we = 1'b0; p_wstrb = '0;
      forever begin
         @(negedge clk);
         if (if_valid && d_valid) chk("both_valid", 32'(if_valid & d_valid), 32'd0);
         if (if_valid || d_valid) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_valid", {30'd0, if_valid, d_valid}, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_kind", 32'(if_valid), 32'(r.is_fetch));
               if (r.is_fetch) begin
                  chk("if_rdata", if_rdata, r.rdata);
                  chk("stall_if_at_valid", 32'(stall_if), 32'd0);
               end else begin
                  chk("d_rdata", d_rdata, r.rdata);
                  chk("stall_mem_at_valid", 32'(stall_mem), 32'd0);
               end
            end
         end
         if (mem_req && prev_wait) begin
            chk("hold_addr", mem_addr, p_addr);
            chk("hold_we", 32'(mem_we), 32'(p_we));
            chk("hold_wdata", mem_wdata, p_wdata);
         end
         if (mem_req && mem_ready) begin
            last_wait_run = run;
            if (req_q.size() == 0) begin
               chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
            end else begin
               q = req_q.pop_front();
               chk("mem_we", 32'(mem_we), 32'(q.we));
               chk("mem_addr", mem_addr, q.addr);
               chk("mem_wdata", mem_wdata, q.wdata);
               chk("mem_wstrb", 32'(mem_wstrb), 32'(q.wstrb));
            end
         end
         if (mem_req && !mem_ready) run++;
         else run = 0;
         prev_wait = mem_req && !mem_ready;
         p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
      end
   end

   // Returns at the drive point (just after the edge ending the valid cycle).
   task automatic wait_any_valid(output logic is_fetch, output int vcyc);
      int  n    = 0;
      bit  done = 0;
      is_fetch = 1'b0;
      vcyc     = 0;
      while (!done) begin
         @(negedge clk);
         if (if_valid || d_valid) begin
            is_fetch = if_valid;
            vcyc     = cyc;
            done     = 1;
         end else if (++n > 60) begin
            chk("valid_timeout", 32'd0, 32'd1);
            done = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   // Returns at the drive point of the first WAIT cycle.
   task automatic wait_accept();
      int n    = 0;
      bit done = 0;
      while (!done) begin
         @(negedge clk);
         if (mem_req && mem_ready) done = 1;
         else if (++n > 60) begin
            chk("accept_timeout", 32'd0, 32'd1);
            done = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      @(negedge clk);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
      chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
      chk({tag, "_d_valid"}, 32'(d_valid), 32'd0);
      chk({tag, "_if_rdata"}, if_rdata, 32'd0);
      chk({tag, "_d_rdata"}, d_rdata, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input bit lat);
      logic isf;
      int   c0, cv;
      req_q.push_back('{we: 1'b0, addr: a, wdata: 32'd0, wstrb: 4'd0});
      rsp_q.push_back('{is_fetch: 1'b0, rdata: exp});
      c0     = cyc;
      d_we   = 1'b0;
      d_addr = a;
      d_req  = 1'b1;
      wait_any_valid(isf, cv);
      chk("load_kind", 32'(isf), 32'd0);
      if (lat) chk("load_latency", 32'(cv), 32'(c0 + 3));
      d_req = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic isf, isf2;
      int   cv, cv2, dcount;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_all_zero("reset");

      // Single load with immediate memory.
      do_load(32'h100, 32'hDEADBEEF, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // Reset while a fetch sits in WAIT; the late response must be dropped.
      hold_rsp = 1;
      req_q.push_back('{we: 1'b0, addr: 32'h60, wdata: 32'd0, wstrb: 4'd0});
      if_addr = 32'h60;
      if_req  = 1'b1;
      wait_accept();
      rst    = 1'b1;
      if_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_all_zero("rst_wait");
      hold_rsp = 0;
      repeat (6) @(posedge clk);
      #1;

      // Store and fetch contend: store first, fetch four cycles later.
      req_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h1234, wstrb: 4'h3});
      req_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'd0, wstrb: 4'h0});
      rsp_q.push_back('{is_fetch: 1'b0, rdata: 32'd0});
      rsp_q.push_back('{is_fetch: 1'b1, rdata: 32'hC0DE0040});
      d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234; d_wstrb = 4'h3; d_req = 1'b1;
      if_addr = 32'h40; if_req = 1'b1;
      wait_any_valid(isf, cv);
      d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
      wait_any_valid(isf2, cv2);
      if_req = 1'b0;
      chk("contend_first_is_data", 32'(isf), 32'd0);
      chk("contend_second_is_fetch", 32'(isf2), 32'd1);
      chk("contend_gap", 32'(cv2 - cv), 32'd4);

      // Fairness: four data grants, then the waiting fetch, then data again.
      for (int i = 0; i < 4; i++) begin
         req_q.push_back('{we: 1'b0, addr: 32'h400 + 32'(4 * i), wdata: 32'd0, wstrb: 4'd0});
         rsp_q.push_back('{is_fetch: 1'b0, rdata: 32'hC0DE0400 + 32'(4 * i)});
      end
      req_q.push_back('{we: 1'b0, addr: 32'h50, wdata: 32'd0, wstrb: 4'd0});
      rsp_q.push_back('{is_fetch: 1'b1, rdata: 32'hC0DE0050});
      req_q.push_back('{we: 1'b0, addr: 32'h410, wdata: 32'd0, wstrb: 4'd0});
      rsp_q.push_back('{is_fetch: 1'b0, rdata: 32'hC0DE0410});
      d_addr = 32'h400; d_req = 1'b1;
      if_addr = 32'h50; if_req = 1'b1;
      dcount = 0;
      for (int k = 0; k < 6; k++) begin
         wait_any_valid(isf, cv);
         if (isf) begin
            if_req = 1'b0;
            chk("fair_fetch_after_4", 32'(dcount), 32'd4);
         end else begin
            dcount++;
            if (dcount < 5) d_addr = 32'h400 + 32'(4 * dcount);
            else d_req = 1'b0;
         end
      end
      chk("fair_streak_cleared", 32'(dut.streak_q), 32'd0);

      // Kill a fetch during WAIT: memory completes, no pulse, data kept.
      hold_rsp = 1;
      req_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'd0, wstrb: 4'd0});
      if_addr = 32'h80;
      if_req  = 1'b1;
      wait_accept();
      if_kill = 1'b1;
      if_req  = 1'b0;
      @(posedge clk); #1;
      if_kill  = 1'b0;
      hold_rsp = 0;
      repeat (6) @(posedge clk);
      #1;
      chk("kill_if_rdata_kept", if_rdata, 32'hC0DE0050);
      do_load(32'h200, 32'hC0DE0200, 1'b1);

      // Backpressure: mem_ready low for five cycles.
      ready_hold = 5;
      do_load(32'h104, 32'hC0DE0104, 1'b0);
      ready_hold = 0;
      chk("backpressure_wait_cycles", 32'(last_wait_run), 32'd5);

      repeat (4) @(posedge clk);
      chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      chk("req_queue_drained", 32'(req_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the RV32I pipeline: shares one unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store). One transaction is outstanding at a time. Data accesses have priority, and a fairness counter stops fetch from starving. The block drives the stall_if/stall_mem inputs of the pipeline control alongside the hazard detection unit, and honors a fetch-kill from branch resolution.

## Interface

Parameters:

- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- FAIR_LIMIT, 4, consecutive data grants allowed while a fetch waits; range 1..15

Ports:

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high with if_addr stable until the if_valid cycle
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  discard the in-flight or granted fetch (branch taken / flush)
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction, registered
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata/d_wstrb stable until the d_valid cycle
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte enables for stores
- d_valid  out  1  one-cycle pulse; load data valid or store acknowledged
- d_rdata  out  DATA_W  load data, registered; updated only on loads
- mem_req  out  1  request to memory; held until accepted
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request; mem_wstrb = 0 for fetches
- mem_ready  in  1  memory accepts the request this cycle when mem_req is high
- mem_rvalid  in  1  response or write-ack, exactly one per accepted request
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid
- stall_if  out  1  combinational: if_req & ~if_valid
- stall_mem  out  1  combinational: d_req & ~d_valid

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**: evaluate requests.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant data, unless streak == FAIR_LIMIT, in which case grant fetch.
  - On grant: latch owner and request fields into the mem_* registers, then go to ISSUE.
- **ISSUE**: mem_req = 1. When mem_ready = 1, go to WAIT.
- **WAIT**: when mem_rvalid = 1, capture mem_rdata into the owner's rdata register, then go to RESP.
  - Exception: a killed fetch still consumes its response, but if_rdata is not updated.
- **RESP**: pulse the owner's valid for one cycle (suppressed if killed), then go to IDLE. Requests are not sampled in RESP, so a requester can drop or change its request in this cycle.
- **streak counter** (4 bits):
  - Data grant while if_req = 1: increment, saturating at FAIR_LIMIT.
  - Data grant while if_req = 0: clear to 0.
  - Any fetch grant: clear to 0.
- **kill flag**:
  - Set when if_kill = 1 while owner = fetch in ISSUE, WAIT or RESP.
  - Cleared on entering IDLE.
  - if_kill in IDLE has no effect.
  - Kill does not abort mem_req; the transaction completes on the memory side.
- mem_rvalid outside WAIT is ignored. mem_ready outside ISSUE is ignored.

## Timing

- **Reset** (synchronous, any state, including mid-transaction):
  - State = IDLE; streak = 0; kill = 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_valid, d_valid, if_rdata, d_rdata.
  - The in-flight response is dropped. The memory is reset by the same rst.
- **Latency**: request seen in IDLE at cycle t → mem_req high from t+1.
  - With mem_ready at t+1 and mem_rvalid at t+2: valid pulse at t+3, IDLE at t+4.
  - Minimum 4 cycles per access, so peak throughput is 1 access per 4 cycles.
- mem_* outputs stay stable from ISSUE entry through WAIT.
- Each valid pulse is exactly one cycle, and only one of if_valid/d_valid is high at a time.
- **Simultaneous events**:
  - if_kill in the same cycle as mem_rvalid: response discarded.
  - if_kill in the RESP cycle: if_valid suppressed.
- Streak saturation: with FAIR_LIMIT = 4, a waiting fetch is granted after at most 4 data grants.

## Test plan

- Reset mid-WAIT: assert rst while state = WAIT → next cycle all outputs 0 and state = IDLE; a late mem_rvalid = 1 produces no valid pulse.
- Single load: d_req = 1, d_we = 0, d_addr = 0x100; mem_ready immediate, mem_rvalid one cycle later with 0xDEADBEEF → d_valid pulses at t+3, d_rdata = 0xDEADBEEF, stall_mem low from the d_valid cycle.
- Store then fetch contention: d_req (store, wstrb = 0x3, wdata = 0x1234) and if_req (addr 0x40) both high → store issued first with mem_wstrb = 0x3; fetch issued next with mem_wstrb = 0; if_valid follows d_valid by 4 cycles.
- Fairness: d_req held high with back-to-back loads, if_req high, FAIR_LIMIT = 4 → exactly 4 data grants, then a fetch grant; streak returns to 0.
- Kill: fetch of 0x80 granted, if_kill pulsed during WAIT → memory handshake completes, if_valid never pulses, if_rdata unchanged; next request is granted normally.
- Memory backpressure: mem_ready held low for 5 cycles → mem_req and mem_addr stable for all 5 cycles; completion proceeds normally.
